// File: rtl/bcd_cascade_counter_if.sv
// Control/data bundle for bcd_cascade_counter: count controls and load word in, count, terminal count and wrap flag out.
interface bcd_cascade_counter_if #(
  parameter int DIGITS = 2
);
  logic                  enable;
  logic                  load;
  logic                  up;
  logic [4*DIGITS-1:0]   D;
  logic [4*DIGITS-1:0]   Q;
  logic                  Co;
  logic                  ovf;

  modport master (output enable, load, up, D, input Q, Co, ovf);
  modport slave  (input enable, load, up, D, output Q, Co, ovf);
endinterface

// File: rtl/bcd_cascade_counter.sv
// Up/down counter of DIGITS cascaded radix-RADIX digit cells with a combinational ripple-enable chain,
// clamped parallel load, combinational terminal count (Co) and a sticky full-word wrap flag (ovf).
module bcd_cascade_counter #(
  parameter int DIGITS = 2,
  parameter int RADIX  = 10
) (
  input  logic                     clk,
  input  logic                     clr,
  bcd_cascade_counter_if.slave     bus
);
  localparam int         W       = 4 * DIGITS;
  localparam logic [3:0] DIG_MAX = 4'(RADIX - 1);

  logic [W-1:0]      q_q, q_d;
  logic              ovf_q, ovf_d;
  logic [DIGITS-1:0] tc;
  logic [DIGITS:0]   ripple;
  logic              co;

  // ripple[i] is high when every digit below i sits at its terminal value for the current direction.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can leave it unassigned (no latch).
    tc        = '0;
    ripple    = '0;
    ripple[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      tc[i]       = bus.up ? (q_q[4*i +: 4] == DIG_MAX) : (q_q[4*i +: 4] == 4'd0);
      ripple[i+1] = ripple[i] & tc[i];
    end
  end

  assign co = bus.enable & ~bus.load & ~clr & ripple[DIGITS];

  always_comb begin
    q_d   = q_q;
    ovf_d = ovf_q;
    if (bus.load) begin
      // Clamping keeps every digit inside 0..RADIX-1, so the step logic never sees an illegal digit.
      for (int i = 0; i < DIGITS; i++) begin
        q_d[4*i +: 4] = (bus.D[4*i +: 4] > DIG_MAX) ? DIG_MAX : bus.D[4*i +: 4];
      end
      ovf_d = 1'b0;
    end else if (bus.enable) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (ripple[i]) begin
          if (bus.up) q_d[4*i +: 4] = (q_q[4*i +: 4] == DIG_MAX) ? 4'd0 : q_q[4*i +: 4] + 4'd1;
          else        q_d[4*i +: 4] = (q_q[4*i +: 4] == 4'd0) ? DIG_MAX : q_q[4*i +: 4] - 4'd1;
        end
      end
      ovf_d = ovf_q | co;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (clr) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.Q   = q_q;
  assign bus.Co  = co;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Self-checking bench: integer-valued reference model per instance, per-cycle compare, pinned literal checks, random phase.
module tb_bcd_cascade_counter;
  logic        clk = 1'b0;
  logic        clr, en, ld, up;
  logic [7:0]  d2;
  logic [11:0] d3;
  bit          armed = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  bcd_cascade_counter_if #(.DIGITS(2)) if2 ();
  bcd_cascade_counter_if #(.DIGITS(3)) if3 ();
  bcd_cascade_counter_if #(.DIGITS(2)) ifl ();
  bcd_cascade_counter_if #(.DIGITS(2)) ifh ();

  assign if2.enable = en;  assign if2.load = ld; assign if2.up = up; assign if2.D = d2;
  assign if3.enable = en;  assign if3.load = ld; assign if3.up = up; assign if3.D = d3;
  assign ifl.enable = en;  assign ifl.load = ld; assign ifl.up = up; assign ifl.D = d2;
  assign ifh.enable = ifl.Co; assign ifh.load = ld; assign ifh.up = up; assign ifh.D = d2;

  bcd_cascade_counter #(.DIGITS(2), .RADIX(10)) u2 (.clk(clk), .clr(clr), .bus(if2));
  bcd_cascade_counter #(.DIGITS(3), .RADIX(16)) u3 (.clk(clk), .clr(clr), .bus(if3));
  bcd_cascade_counter #(.DIGITS(2), .RADIX(10)) ul (.clk(clk), .clr(clr), .bus(ifl));
  bcd_cascade_counter #(.DIGITS(2), .RADIX(10)) uh (.clk(clk), .clr(clr), .bus(ifh));

  // Reference model: each counter is a plain integer modulo RADIX^DIGITS.
  int m2, m3, ml, mh;
  bit ovf2, ovf3, ovfl, ovfh;

  function automatic int step_n(int n, int m, bit dir_up);
    return dir_up ? (n + 1) % m : (n + m - 1) % m;
  endfunction

  function automatic int load_val(logic [31:0] d, int digits, int radix);
    int sum = 0;
    int p = 1;
    for (int i = 0; i < digits; i++) begin
      int dig = int'((d >> (4*i)) & 32'hF);
      if (dig > radix - 1) dig = radix - 1;
      sum += dig * p;
      p   *= radix;
    end
    return sum;
  endfunction

  function automatic logic [31:0] enc(int n, int digits, int radix);
    logic [31:0] r = '0;
    int v = n;
    for (int i = 0; i < digits; i++) begin
      r |= 32'(v % radix) << (4*i);
      v /= radix;
    end
    return r;
  endfunction

  function automatic bit co_g(bit e, int n, int m);
    return e & !ld & !clr & (up ? (n == m - 1) : (n == 0));
  endfunction

  always @(posedge clk) begin
    if (clr) begin
      m2 <= 0; m3 <= 0; ml <= 0; mh <= 0;
      ovf2 <= 0; ovf3 <= 0; ovfl <= 0; ovfh <= 0;
    end else if (ld) begin
      m2 <= load_val(32'(d2), 2, 10); m3 <= load_val(32'(d3), 3, 16);
      ml <= load_val(32'(d2), 2, 10); mh <= load_val(32'(d2), 2, 10);
      ovf2 <= 0; ovf3 <= 0; ovfl <= 0; ovfh <= 0;
    end else begin
      if (en) begin
        m2 <= step_n(m2, 100, up);  ovf2 <= ovf2 | co_g(en, m2, 100);
        m3 <= step_n(m3, 4096, up); ovf3 <= ovf3 | co_g(en, m3, 4096);
        ml <= step_n(ml, 100, up);  ovfl <= ovfl | co_g(en, ml, 100);
      end
      if (co_g(en, ml, 100)) begin
        mh   <= step_n(mh, 100, up);
        ovfh <= ovfh | co_g(1'b1, mh, 100);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      check("u2_q",   32'(if2.Q),   enc(m2, 2, 10));
      check("u2_co",  32'(if2.Co),  32'(co_g(en, m2, 100)));
      check("u2_ovf", 32'(if2.ovf), 32'(ovf2));
      check("u3_q",   32'(if3.Q),   enc(m3, 3, 16));
      check("u3_co",  32'(if3.Co),  32'(co_g(en, m3, 4096)));
      check("u3_ovf", 32'(if3.ovf), 32'(ovf3));
      check("lo_q",   32'(ifl.Q),   enc(ml, 2, 10));
      check("lo_co",  32'(ifl.Co),  32'(co_g(en, ml, 100)));
      check("lo_ovf", 32'(ifl.ovf), 32'(ovfl));
      check("hi_q",   32'(ifh.Q),   enc(mh, 2, 10));
      check("hi_co",  32'(ifh.Co),  32'(co_g(co_g(en, ml, 100), mh, 100)));
      check("hi_ovf", 32'(ifh.ovf), 32'(ovfh));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    clr = 1'b1; ld = 1'b1; en = 1'b1; up = 1'b1; d2 = 8'h55; d3 = 12'h555;
    tick(1);
    armed = 1'b1;
    check("rst_q",   32'(if2.Q),   32'h00);
    check("rst_ovf", 32'(if2.ovf), 32'h0);
    check("rst_co",  32'(if2.Co),  32'h0);

    clr = 1'b0; ld = 1'b0; en = 1'b1; up = 1'b1;
    tick(9);  check("up_09", 32'(if2.Q), 32'h09);
    tick(1);  check("up_10", 32'(if2.Q), 32'h10);
    tick(9);  check("up_19", 32'(if2.Q), 32'h19);
    tick(1);  check("up_20", 32'(if2.Q), 32'h20);
    tick(79); check("up_99", 32'(if2.Q), 32'h99);
    check("up_co99", 32'(if2.Co), 32'h1);
    tick(1);  check("up_wrap_q", 32'(if2.Q), 32'h00);
    check("up_wrap_ovf", 32'(if2.ovf), 32'h1);
    check("casc_hi", 32'(ifh.Q), 32'h01);
    check("casc_lo", 32'(ifl.Q), 32'h00);

    up = 1'b0; #1;
    check("dn_co00", 32'(if2.Co), 32'h1);
    tick(1);  check("dn_99", 32'(if2.Q), 32'h99);
    check("dn_ovf", 32'(if2.ovf), 32'h1);
    tick(1);  check("dn_98", 32'(if2.Q), 32'h98);
    tick(8);  check("dn_90", 32'(if2.Q), 32'h90);
    tick(1);  check("dn_89", 32'(if2.Q), 32'h89);

    ld = 1'b1; d2 = 8'h3F;
    tick(1);  check("ld_39", 32'(if2.Q), 32'h39);
    check("ld_ovf", 32'(if2.ovf), 32'h0);
    d2 = 8'hA7;
    tick(1);  check("ld_97", 32'(if2.Q), 32'h97);
    ld = 1'b0; en = 1'b0;
    tick(5);  check("hold_q", 32'(if2.Q), 32'h97);
    check("hold_co", 32'(if2.Co), 32'h0);

    ld = 1'b1; en = 1'b1; up = 1'b1; d3 = 12'hFFE;
    tick(1);  check("hx_ffe", 32'(if3.Q), 32'hFFE);
    ld = 1'b0;
    tick(1);  check("hx_fff", 32'(if3.Q), 32'hFFF);
    tick(1);  check("hx_000", 32'(if3.Q), 32'h000);
    check("hx_ovf", 32'(if3.ovf), 32'h1);
    up = 1'b0; #1;
    check("hx_co_flip", 32'(if3.Co), 32'h1);
    tick(1);  check("hx_dn_fff", 32'(if3.Q), 32'hFFF);

    for (int i = 0; i < 1500; i++) begin
      clr = ($urandom_range(31) == 0);
      ld  = ($urandom_range(7) == 0);
      en  = ($urandom_range(3) != 0);
      up  = (i / 200) % 2 == 0 ? ($urandom_range(7) != 0) : ($urandom_range(7) == 0);
      d2  = 8'($urandom);
      d3  = 12'($urandom);
      tick(1);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
